// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters, tagged response.
// Optional per-requester grant counters are enabled with `define ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_data1_i,
    input  logic [31:0] req0_data2_i,
    input  logic [2:0]  req0_ctrl_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_data1_i,
    input  logic [31:0] req1_data2_i,
    input  logic [2:0]  req1_ctrl_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_data_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_zero_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat_grant0_o,
    output logic [15:0] stat_grant1_o
`endif
);

    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latency parameters outside 1..15 are pulled into range so the 4-bit counter never stalls.
    function automatic logic [3:0] clamp_lat(input int lat);
        if (lat < 1) return 4'd1;
        if (lat > 15) return 4'd15;
        return lat[3:0];
    endfunction

    localparam logic [3:0] ALU_CNT = clamp_lat(ALU_LAT);
    localparam logic [3:0] MUL_CNT = clamp_lat(MUL_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        grant1;
    logic        accept;
    logic [31:0] sel_data1;
    logic [31:0] sel_data2;
    logic [2:0]  sel_ctrl;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    always_comb begin
        grant1    = req1_valid_i && (!req0_valid_i || !last_grant);
        accept    = (state == IDLE) && !rst_i && (req0_valid_i || req1_valid_i);
        sel_data1 = grant1 ? req1_data1_i : req0_data1_i;
        sel_data2 = grant1 ? req1_data2_i : req0_data2_i;
        sel_ctrl  = grant1 ? req1_ctrl_i  : req0_ctrl_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (accept) begin
            req0_ready_o = !grant1;
            req1_ready_o = grant1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= 4'd0;
            last_grant  <= 1'b1;
            alu_data1_o <= 32'd0;
            alu_data2_o <= 32'd0;
            alu_ctrl_o  <= 3'd0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_data_o  <= 32'd0;
            rsp_zero_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    alu_data1_o <= sel_data1;
                    alu_data2_o <= sel_data2;
                    alu_ctrl_o  <= sel_ctrl;
                    last_grant  <= grant1;
                    rsp_id_o    <= grant1;
                    cnt         <= (sel_ctrl == OP_MUL) ? MUL_CNT : ALU_CNT;
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_data_o  <= alu_data_i;
                        rsp_zero_o  <= alu_zero_i;
                        rsp_valid_o <= 1'b1;
                    end
                end
                RESP: if (rsp_ready_i) rsp_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_grant0_o <= 16'd0;
            stat_grant1_o <= 16'd0;
        end else if (accept) begin
            if (grant1) stat_grant1_o <= sat_inc(stat_grant1_o);
            else        stat_grant0_o <= sat_inc(stat_grant0_o);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic [2:0]  req0_ctrl_i, req1_ctrl_i;
    logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
    logic [2:0]  alu_ctrl_o;
    logic        alu_zero_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o;
    logic [31:0] rsp_data_o;

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o)
    );

    // Behavioural ALU attached to the DUT, also used to predict response data.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        case (c)
            3'b001:  return a + b;
            3'b010:  return a - b;
            3'b011:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b110:  return a * b;
            3'b111:  return $unsigned($signed(a) >>> b[4:0]);
            default: return a << b[4:0];
        endcase
    endfunction

    assign alu_data_i = alu_f(alu_data1_o, alu_data2_o, alu_ctrl_o);
    assign alu_zero_i = (alu_data_i == 32'd0);

    int total = 0;
    int bad   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: an op accepted in cycle c responds from cycle c+1+lat until the handshake.
    bit          m_en = 1'b0;
    bit          m_busy, m_last, m_id, m_zero, m_any, m_win, m_v, m_r0, m_r1;
    int          m_due;
    logic [31:0] m_a1, m_a2, m_data;
    logic [2:0]  m_ctrl;

    function automatic int lat_of(input logic [2:0] c);
        return (c == 3'b110) ? MUL_LAT : ALU_LAT;
    endfunction

    always @(negedge clk) begin
        if (rst_i) begin
            m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_zero = 1'b0; m_due = 0;
            m_a1 = '0; m_a2 = '0; m_ctrl = '0; m_data = '0;
        end else if (m_en) begin
            if (m_busy && cyc == m_due) begin
                m_data = alu_f(m_a1, m_a2, m_ctrl);
                m_zero = (m_data == 32'd0);
            end
            m_v   = m_busy && (cyc >= m_due);
            m_any = req0_valid_i || req1_valid_i;
            if (req0_valid_i && req1_valid_i) m_win = ~m_last;
            else                              m_win = req1_valid_i;
            m_r0 = !m_busy && m_any && (m_win == 1'b0);
            m_r1 = !m_busy && m_any && (m_win == 1'b1);
            check1("m_ready0", req0_ready_o, m_r0);
            check1("m_ready1", req1_ready_o, m_r1);
            check1("m_rsp_valid", rsp_valid_o, m_v);
            check1("m_rsp_id", rsp_id_o, m_id);
            check32("m_rsp_data", rsp_data_o, m_data);
            check1("m_rsp_zero", rsp_zero_o, m_zero);
            check32("m_alu_d1", alu_data1_o, m_a1);
            check32("m_alu_d2", alu_data2_o, m_a2);
            check32("m_alu_ctrl", {29'd0, alu_ctrl_o}, {29'd0, m_ctrl});
            if (m_v) begin
                if (rsp_ready_i) m_busy = 1'b0;
            end else if (!m_busy && m_any) begin
                m_busy = 1'b1;
                m_last = m_win;
                m_id   = m_win;
                m_a1   = m_win ? req1_data1_i : req0_data1_i;
                m_a2   = m_win ? req1_data2_i : req0_data2_i;
                m_ctrl = m_win ? req1_ctrl_i  : req0_ctrl_i;
                m_due  = cyc + 1 + lat_of(m_ctrl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req0_valid_i = 1'b1; req0_data1_i = a; req0_data2_i = b; req0_ctrl_i = c;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req1_valid_i = 1'b1; req1_data1_i = a; req1_data2_i = b; req1_ctrl_i = c;
    endtask

    int acc_cyc[$];
    bit acc_id[$];
    bit exp_ids[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_i = 1'b1; rsp_ready_i = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_data1_i = '0; req0_data2_i = '0; req0_ctrl_i = '0;
        req1_data1_i = '0; req1_data2_i = '0; req1_ctrl_i = '0;
        tick(); tick();
        rst_i = 1'b0; m_en = 1'b1;
        #1;
        check32("rst_alu_d1", alu_data1_o, 32'd0);
        check32("rst_alu_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        check1("rst_rsp_valid", rsp_valid_o, 1'b0);
        check32("rst_rsp_data", rsp_data_o, 32'd0);
        check1("rst_ready0", req0_ready_o, 1'b0);
        check1("rst_ready1", req1_ready_o, 1'b0);

        // ADD 5,7 from requester 0
        tick();
        drive0(32'd5, 32'd7, 3'b001);
        #1 check1("add_ready0", req0_ready_o, 1'b1);
        tick(); req0_valid_i = 1'b0;
        #1 check32("add_alu_ctrl", {29'd0, alu_ctrl_o}, 32'd1);
        check1("add_not_yet", rsp_valid_o, 1'b0);
        tick();
        #1 check1("add_valid", rsp_valid_o, 1'b1);
        check32("add_data", rsp_data_o, 32'd12);
        check1("add_zero", rsp_zero_o, 1'b0);
        check1("add_id", rsp_id_o, 1'b0);
        tick();

        // SUB 9,9 from requester 0 gives zero
        drive0(32'd9, 32'd9, 3'b010);
        #1 check1("sub_ready0", req0_ready_o, 1'b1);
        tick(); req0_valid_i = 1'b0;
        tick();
        #1 check1("sub_valid", rsp_valid_o, 1'b1);
        check32("sub_data", rsp_data_o, 32'd0);
        check1("sub_zero", rsp_zero_o, 1'b1);
        tick();

        // MUL 3,4 from requester 1 uses the longer latency
        drive1(32'd3, 32'd4, 3'b110);
        #1 check1("mul_ready1", req1_ready_o, 1'b1);
        check1("mul_ready0", req0_ready_o, 1'b0);
        tick(); req1_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check1("mul_not_yet", rsp_valid_o, 1'b0);
            tick();
        end
        #1 check1("mul_valid", rsp_valid_o, 1'b1);
        check32("mul_data", rsp_data_o, 32'd12);
        check1("mul_id", rsp_id_o, 1'b1);
        tick();

        // Both requesters valid continuously: alternating grants three cycles apart
        drive0(32'd10, 32'd20, 3'b001);
        drive1(32'hF0F0, 32'h0FF0, 3'b101);
        for (int k = 0; k < 30 && acc_cyc.size() < 4; k++) begin
            #1;
            if (req0_ready_o) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b0); end
            else if (req1_ready_o) begin acc_cyc.push_back(cyc); acc_id.push_back(1'b1); end
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        check32("rr_accepts", acc_cyc.size(), 32'd4);
        for (int i = 0; i < acc_cyc.size() && i < 4; i++) begin
            check1("rr_order", acc_id[i], exp_ids[i]);
            if (i > 0) check32("rr_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd3);
        end
        tick(); tick(); tick();

        // Consumer stalls the response for five cycles
        rsp_ready_i = 1'b0;
        drive0(32'hFF00FF00, 32'h0F0F0F0F, 3'b011);
        #1 check1("stall_ready0", req0_ready_o, 1'b1);
        tick();
        req0_valid_i = 1'b0;
        drive0(32'd3, 32'd5, 3'b101);
        drive1(32'd1, 32'd2, 3'b100);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1 check1("stall_valid", rsp_valid_o, 1'b1);
            check32("stall_data", rsp_data_o, 32'h0F000F00);
            check1("stall_ready0_low", req0_ready_o, 1'b0);
            check1("stall_ready1_low", req1_ready_o, 1'b0);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1 check1("release_valid", rsp_valid_o, 1'b1);
        check1("release_ready1_low", req1_ready_o, 1'b0);
        tick();
        #1 check1("after_release_ready1", req1_ready_o, 1'b1);
        check1("after_release_ready0", req0_ready_o, 1'b0);
        tick();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tick(); tick(); tick();

        // Reset during EXEC of a requester-1 op aborts it
        drive1(32'd6, 32'd7, 3'b110);
        #1 check1("abort_ready1", req1_ready_o, 1'b1);
        tick();
        req1_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1 check32("abort_alu_d1", alu_data1_o, 32'd0);
        check32("abort_alu_d2", alu_data2_o, 32'd0);
        check32("abort_alu_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        check1("abort_rsp_valid", rsp_valid_o, 1'b0);
        check32("abort_rsp_data", rsp_data_o, 32'd0);
        check1("abort_rsp_id", rsp_id_o, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            #1 check1("abort_no_rsp", rsp_valid_o, 1'b0);
        end
        drive0(32'd1, 32'd1, 3'b001);
        drive1(32'd5, 32'd3, 3'b010);
        #1 check1("post_rst_ready0", req0_ready_o, 1'b1);
        check1("post_rst_ready1", req1_ready_o, 1'b0);
        tick(); req0_valid_i = 1'b0;
        tick(); tick();
        #1 check1("post_rst_second", req1_ready_o, 1'b1);
        tick(); req1_valid_i = 1'b0;
        tick(); tick(); tick();

        m_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
